// File: rtl/gpio_spi_expander_if.sv
// SPI pin bundle between the board controller (master) and the IO expander (slave).
// Latency: none, wires only.
// Backpressure: none; SPI has no flow control, the master owns all timing.
// Ports: spi_sclk, spi_cs_n, spi_mosi driven by master; spi_miso, spi_miso_oe driven by slave.
interface gpio_spi_expander_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/gpio_spi_expander.sv
// SPI mode-0 slave: shifts a WIDTH-bit frame in to gpio_out, shifts a gpio_in snapshot out on MISO.
// Latency: pin edge -> action SYNC_STAGES+1 clk; cs_n rise -> gpio_out/stb SYNC_STAGES+2 clk.
// Backpressure: none; the master paces everything, clk must be >= 4x spi_sclk.
// Ports: clk, rst (sync, active-high); spi (slave modport: sclk/cs_n/mosi in, miso/miso_oe out);
//        gpio_in (snapshot at frame start); gpio_out + gpio_out_stb (complete frame); frame_err.
module gpio_spi_expander #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic               clk,
  input  logic               rst,
  gpio_spi_expander_if.slave spi,
  input  logic [WIDTH-1:0]   gpio_in,
  output logic [WIDTH-1:0]   gpio_out,
  output logic               gpio_out_stb,
  output logic               frame_err
);

  localparam int              CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(WIDTH + 1);

  typedef enum logic [1:0] {WAIT_CS, IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  // Synchronisers, one history flop each, and registered single-clk edge pulses.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_h, cs_h, mosi_h;
  logic                   sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
  // Fills with ones after reset; once full, the history flops reflect the real pins
  // rather than reset values, so a low cs_n held through reset cannot look like a fresh fall.
  logic [SYNC_STAGES+1:0] settle_sr;
  logic                   settled;

  logic [WIDTH-1:0] tx_sr, rx_sr;
  logic [CW-1:0]    bit_cnt;

  logic start, rx_shift, tx_shift, finish_ok, finish_err;

  assign settled = settle_sr[SYNC_STAGES+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync   <= '0;
      cs_sync     <= '1;
      mosi_sync   <= '0;
      sclk_h      <= 1'b0;
      cs_h        <= 1'b1;
      mosi_h      <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      settle_sr   <= '0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_h      <= sclk_sync[SYNC_STAGES-1];
      cs_h        <= cs_sync[SYNC_STAGES-1];
      // mosi_h is sampled in the same clk as sclk_h, so it is the bit aligned with sclk_rise_q.
      mosi_h      <= mosi_sync[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync[SYNC_STAGES-1] & ~sclk_h;
      sclk_fall_q <= ~sclk_sync[SYNC_STAGES-1] & sclk_h;
      cs_rise_q   <= cs_sync[SYNC_STAGES-1] & ~cs_h;
      cs_fall_q   <= ~cs_sync[SYNC_STAGES-1] & cs_h;
      settle_sr   <= {settle_sr[SYNC_STAGES:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_CS;
    else     state <= state_nxt;
  end

  // cs_rise wins over any coincident sclk edge; sclk edges outside ACTIVE are dropped.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    rx_shift   = 1'b0;
    tx_shift   = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      WAIT_CS: if (settled && cs_h) state_nxt = IDLE;
      IDLE: begin
        if (cs_fall_q) begin
          start     = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise_q) begin
          state_nxt = IDLE;
          if (bit_cnt == CNT_FULL) finish_ok  = 1'b1;
          else                     finish_err = 1'b1;
        end else begin
          rx_shift = sclk_rise_q;
          tx_shift = sclk_fall_q;
        end
      end
      default: state_nxt = WAIT_CS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out        <= RESET_VAL;
      gpio_out_stb    <= 1'b0;
      frame_err       <= 1'b0;
      spi.spi_miso    <= 1'b0;
      spi.spi_miso_oe <= 1'b0;
      tx_sr           <= '0;
      rx_sr           <= '0;
      bit_cnt         <= '0;
    end else begin
      gpio_out_stb <= finish_ok;
      frame_err    <= finish_err;
      if (start) begin
        tx_sr           <= gpio_in;
        rx_sr           <= '0;
        bit_cnt         <= '0;
        spi.spi_miso_oe <= 1'b1;
        spi.spi_miso    <= gpio_in[WIDTH-1];
      end
      if (rx_shift) begin
        rx_sr <= {rx_sr[WIDTH-2:0], mosi_h};
        // Saturate one past full so over-length frames never wrap back to a valid count.
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
      end
      if (tx_shift) begin
        tx_sr        <= {tx_sr[WIDTH-2:0], 1'b0};
        spi.spi_miso <= tx_sr[WIDTH-2];
      end
      if (finish_ok || finish_err) begin
        spi.spi_miso_oe <= 1'b0;
        spi.spi_miso    <= 1'b0;
      end
      if (finish_ok) gpio_out <= rx_sr;
    end
  end

endmodule
